wb_divider_master: RTL and testbench
====================================

// Module: wb_divider_master
// PURPOSE
//   Wishbone classic initiator that drives the serial divider's register interface on behalf
//   of a local requester: accepts one {dividend, divisor} request, writes both operands, sets
//   the start bit, polls status until done, reads quotient and remainder, and returns them.
//   Sits between on-chip control logic and the divider's Wishbone slave port. One request in flight.
// PARAMETERS
//   WBW        32           Wishbone data/address width
//   XLEN       32           operand/result width (XLEN <= WBW, zero-extended on the bus)
//   BASE_ADR   32'h3000_0000 divider base address. Offsets: +0x00 DIVIDEND, +0x04 DIVISOR,
//                           +0x08 CTRL (bit0 = start), +0x0C STATUS (bit0 = done),
//                           +0x10 QUOTIENT, +0x14 REMAINDER
//   ACK_TMO    16           max wait cycles for ack per bus transaction before abort
//   MAX_POLLS  64           max STATUS reads before abort
// PORTS
//   clk_i        in   1        clock
//   reset_ni     in   1        asynchronous reset, active low
//   req_valid_i  in   1        request valid
//   req_ready_o  out  1        request ready (high only in IDLE)
//   dividend_i   in   XLEN     dividend, sampled on req handshake
//   divisor_i    in   XLEN     divisor, sampled on req handshake
//   rsp_valid_o  out  1        response valid, held until rsp_ready_i
//   rsp_ready_i  in   1        response accepted
//   quotient_o   out  XLEN     quotient (0 when err_o)
//   remainder_o  out  XLEN     remainder (0 when err_o)
//   err_o        out  1        response error: ack timeout or poll limit exceeded
//   wbm_cyc_o    out  1        Wishbone cycle
//   wbm_stb_o    out  1        Wishbone strobe
//   wbm_we_o     out  1        Wishbone write enable
//   wbm_sel_o    out  WBW/8    byte selects (always all ones when stb)
//   wbm_adr_o    out  WBW      address
//   wbm_dat_o    out  WBW      write data
//   wbm_ack_i    in   1        Wishbone ack
//   wbm_dat_i    in   WBW      read data
// BEHAVIOUR
//   Reset (async assert, sync release): state IDLE; all outputs 0 except req_ready_o = 1.
//   All outputs registered. States: IDLE, WR_DVD, WR_DVS, WR_GO, RD_STAT, RD_QUO, RD_REM, RESP.
//   IDLE: req_valid_i & req_ready_o -> latch operands, go WR_DVD next cycle.
//   Bus state: cyc/stb/we/adr/dat/sel asserted from the first cycle of the state, held stable
//     until the cycle wbm_ack_i = 1; next cycle cyc=stb=0 (one idle cycle) then next state issues.
//     Ack seen with stb low is ignored. Read data captured in the ack cycle.
//   Sequence: WR_DVD (+0x00, dividend) -> WR_DVS (+0x04, divisor) -> WR_GO (+0x08, 1)
//     -> RD_STAT (+0x0C): done bit 1 -> RD_QUO, else repeat RD_STAT (poll count +1)
//     -> RD_QUO (+0x10) -> RD_REM (+0x14) -> RESP. Results = low XLEN bits of read data.
//   Minimum latency, zero-wait slave (ack in 1st stb cycle), done on first poll:
//     6 transactions x 2 cycles = 12 cycles from handshake to rsp_valid_o.
//   Ack timeout: counter reset at each transaction start; if ACK_TMO cycles pass without ack,
//     drop cyc/stb next cycle and go RESP with err_o = 1, results 0.
//   Poll limit: MAX_POLLS STATUS reads with done=0 -> RESP with err_o = 1.
//   RESP: rsp_valid_o = 1 with stable data until rsp_ready_i; then IDLE (req_ready_o = 1 the
//     following cycle; no back-to-back accept in RESP).
//   Divisor 0 is passed through unchanged; divide-by-zero semantics belong to the slave.
//   Reset mid-transaction: cyc/stb drop immediately (async), request is lost, no response.
// TESTING
//   Zero-wait slave model, 100/7 -> quotient 14, remainder 2, err 0, rsp_valid 12 cycles after accept.
//   Slave with 3 wait states and done after 5 polls, 0xFFFF_FFFF/0x10 -> 0x0FFF_FFFF, 0xF.
//   Slave never acks WR_DVS -> cyc drops after ACK_TMO cycles, rsp err_o=1, quotient/remainder 0.
//   Done never set -> exactly MAX_POLLS STATUS reads observed, then err_o=1.
//   rsp_ready_i held low 10 cycles -> rsp_valid_o and data stable; req_valid_i ignored meanwhile.
//   reset_ni pulsed during RD_STAT -> cyc/stb 0 same cycle, req_ready_o=1 after release, no rsp.

Source files
------------

// File: rtl/wb_divider_master.sv
// Wishbone classic initiator for the serial divider: writes operands,
// starts the divider, polls STATUS, reads quotient and remainder back.
module wb_divider_master #(
  parameter int unsigned    WBW       = 32,
  parameter int unsigned    XLEN      = 32,
  parameter logic [WBW-1:0] BASE_ADR  = 32'h3000_0000,
  parameter int unsigned    ACK_TMO   = 16,
  parameter int unsigned    MAX_POLLS = 64
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [XLEN-1:0]  dividend_i,
  input  logic [XLEN-1:0]  divisor_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [XLEN-1:0]  quotient_o,
  output logic [XLEN-1:0]  remainder_o,
  output logic             err_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [WBW/8-1:0] wbm_sel_o,
  output logic [WBW-1:0]   wbm_adr_o,
  output logic [WBW-1:0]   wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [WBW-1:0]   wbm_dat_i
);

  localparam int unsigned TW = $clog2(ACK_TMO + 1);
  localparam int unsigned PW = $clog2(MAX_POLLS + 1);

  typedef enum logic [2:0] {
    IDLE, WR_DVD, WR_DVS, WR_GO,
    RD_STAT, RD_QUO, RD_REM, RESP
  } state_t;

  state_t          state;
  logic            gap;
  logic [XLEN-1:0] dvs;
  logic [TW-1:0]   tmo_cnt;
  logic [PW-1:0]   poll_cnt;

  function automatic logic [WBW-1:0] offset(state_t s);
    logic [WBW-1:0] o;
    case (s)
      WR_DVS:  o = WBW'('h04);
      WR_GO:   o = WBW'('h08);
      RD_STAT: o = WBW'('h0C);
      RD_QUO:  o = WBW'('h10);
      RD_REM:  o = WBW'('h14);
      default: o = '0;
    endcase
    return o;
  endfunction

  // gap marks the idle cycle between transactions; the
  // state already names the transaction to issue next.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state       <= IDLE;
      gap         <= 1'b0;
      dvs         <= '0;
      tmo_cnt     <= '0;
      poll_cnt    <= '0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
      err_o       <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            dvs         <= divisor_i;
            req_ready_o <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
            err_o       <= 1'b0;
            poll_cnt    <= '0;
            tmo_cnt     <= '0;
            gap         <= 1'b0;
            state       <= WR_DVD;
            wbm_cyc_o   <= 1'b1;
            wbm_stb_o   <= 1'b1;
            wbm_we_o    <= 1'b1;
            wbm_sel_o   <= '1;
            wbm_adr_o   <= BASE_ADR;
            wbm_dat_o   <= WBW'(dividend_i);
          end
        end
        RESP: begin
          if (gap) begin
            gap         <= 1'b0;
            rsp_valid_o <= 1'b1;
          end else if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          if (gap) begin
            gap       <= 1'b0;
            tmo_cnt   <= '0;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_sel_o <= '1;
            wbm_we_o  <= (state == WR_DVS) || (state == WR_GO);
            wbm_adr_o <= BASE_ADR + offset(state);
            wbm_dat_o <= (state == WR_DVS) ? WBW'(dvs)
                                           : WBW'(state == WR_GO);
          end else if (wbm_ack_i) begin
            gap       <= 1'b1;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            case (state)
              WR_DVD: state <= WR_DVS;
              WR_DVS: state <= WR_GO;
              WR_GO:  state <= RD_STAT;
              RD_STAT: begin
                if (wbm_dat_i[0]) begin
                  state <= RD_QUO;
                end else if (poll_cnt == PW'(MAX_POLLS - 1)) begin
                  err_o <= 1'b1;
                  state <= RESP;
                end else begin
                  poll_cnt <= poll_cnt + PW'(1);
                end
              end
              RD_QUO: begin
                quotient_o <= wbm_dat_i[XLEN-1:0];
                state      <= RD_REM;
              end
              RD_REM: begin
                remainder_o <= wbm_dat_i[XLEN-1:0];
                state       <= RESP;
              end
              default: state <= IDLE;
            endcase
          end else if (tmo_cnt == TW'(ACK_TMO - 1)) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= '0;
            err_o       <= 1'b1;
            quotient_o  <= '0;
            remainder_o <= '0;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_divider_master.sv
// Directed bench for wb_divider_master with a Wishbone divider slave
// model; responses are checked against plain a/b, a%b arithmetic.
module tb_wb_divider_master;

  localparam int ACK_TMO   = 16;
  localparam int MAX_POLLS = 64;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        req_valid, req_ready_o;
  logic [31:0] dividend, divisor;
  logic        rsp_valid_o, rsp_ready;
  logic [31:0] quotient_o, remainder_o;
  logic        err_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  always #5 clk = ~clk;

  wb_divider_master dut (
    .clk_i       (clk),
    .reset_ni    (reset_ni),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_o),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .err_o       (err_o),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_ack_i   (wbm_ack_i),
    .wbm_dat_i   (wbm_dat_i)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc_n  = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Slave model
  int          ws;
  int          done_at;
  logic        hang_en;
  logic [31:0] hang_adr;
  int          wcnt = 0;
  int          s_polls = 0;
  int          n_stat = 0;
  int          n_dvs_stb = 0;
  logic [31:0] s_dvd = 0, s_dvs = 0, s_q = 0, s_r = 0;
  logic [31:0] off;
  logic        stat_done;
  logic [31:0] log_adr[$];
  logic        log_we[$];
  logic [31:0] log_dat[$];

  assign off       = wbm_adr_o - BASE;
  assign stat_done = (done_at != 0) && (s_polls + 1 >= done_at);
  assign wbm_ack_i = wbm_cyc_o && wbm_stb_o && (wcnt == ws) &&
                     !(hang_en && wbm_adr_o == hang_adr);

  always_comb begin
    wbm_dat_i = '0;
    case (off)
      32'h0C:  wbm_dat_i = {31'b0, stat_done};
      32'h10:  wbm_dat_i = s_q;
      32'h14:  wbm_dat_i = s_r;
      default: wbm_dat_i = '0;
    endcase
  end

  always @(posedge clk) begin
    if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (wbm_stb_o && wbm_adr_o == BASE + 32'h4) n_dvs_stb <= n_dvs_stb + 1;
    if (wbm_ack_i) begin
      log_adr.push_back(wbm_adr_o);
      log_we.push_back(wbm_we_o);
      log_dat.push_back(wbm_dat_o);
      if (wbm_we_o) begin
        if (off == 32'h0) s_dvd <= wbm_dat_o;
        if (off == 32'h4) s_dvs <= wbm_dat_o;
        if (off == 32'h8 && wbm_dat_o[0]) begin
          s_q     <= (s_dvs == 0) ? 32'hFFFF_FFFF : s_dvd / s_dvs;
          s_r     <= (s_dvs == 0) ? s_dvd : s_dvd % s_dvs;
          s_polls <= 0;
        end
      end else if (off == 32'hC) begin
        s_polls <= s_polls + 1;
        n_stat  <= n_stat + 1;
      end
    end
  end

  // Response model and compare process
  logic [31:0] exp_q, exp_r;
  logic        exp_err;
  logic        no_rsp = 1'b0;
  logic        p_stb = 1'b0, p_ack = 1'b0, p_we = 1'b0;
  logic [31:0] p_adr = 0, p_dat = 0;

  task automatic set_model(input logic [31:0] a, input logic [31:0] b,
                           input logic err);
    exp_err = err;
    exp_q   = err ? 32'h0 : a / b;
    exp_r   = err ? 32'h0 : a % b;
  endtask

  always @(negedge clk) begin
    if (reset_ni) begin
      if (no_rsp) begin
        check("no_rsp", {31'b0, rsp_valid_o}, 32'h0);
      end else if (rsp_valid_o) begin
        check("rsp_quotient", quotient_o, exp_q);
        check("rsp_remainder", remainder_o, exp_r);
        check("rsp_err", {31'b0, err_o}, {31'b0, exp_err});
      end
      if (wbm_stb_o) check("sel", {28'b0, wbm_sel_o}, 32'hF);
      if (p_stb && p_ack) check("idle_gap", {31'b0, wbm_stb_o}, 32'h0);
      if (p_stb && !p_ack && wbm_stb_o) begin
        check("hold_adr", wbm_adr_o, p_adr);
        check("hold_we", {31'b0, wbm_we_o}, {31'b0, p_we});
        check("hold_dat", wbm_dat_o, p_dat);
      end
    end
    p_stb = wbm_stb_o;
    p_ack = wbm_ack_i;
    p_adr = wbm_adr_o;
    p_we  = wbm_we_o;
    p_dat = wbm_dat_o;
  end

  task automatic run_req(input logic [31:0] a, input logic [31:0] b,
                         input int hold, output int lat,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic e);
    int n;
    int t_acc;
    lat = -1;
    q   = '0;
    r   = '0;
    e   = 1'b0;
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready", {31'b0, req_ready_o}, 32'h1);
    @(negedge clk);
    t_acc     = cyc_n;
    req_valid = 1'b0;
    check("ready_drop", {31'b0, req_ready_o}, 32'h0);
    n = 0;
    while (!rsp_valid_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("rsp_arrived", {31'b0, rsp_valid_o}, 32'h1);
    if (!rsp_valid_o) return;
    lat = cyc_n - t_acc;
    q   = quotient_o;
    r   = remainder_o;
    e   = err_o;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      dividend  = ~a;
      @(negedge clk);
      check("hold_valid", {31'b0, rsp_valid_o}, 32'h1);
      check("hold_noacc", {31'b0, req_ready_o}, 32'h0);
      check("hold_nocyc", {31'b0, wbm_cyc_o}, 32'h0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", {31'b0, rsp_valid_o}, 32'h0);
    check("ready_back", {31'b0, req_ready_o}, 32'h1);
  endtask

  initial begin
    int          lat;
    int          base;
    int          n;
    logic [31:0] q, r;
    logic        e;
    logic [31:0] wd[3];

    reset_ni  = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    ws        = 0;
    done_at   = 1;
    hang_en   = 1'b0;
    hang_adr  = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready_o}, 32'h1);
    check("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'h0);
    check("rst_cyc", {31'b0, wbm_cyc_o}, 32'h0);
    check("rst_stb", {31'b0, wbm_stb_o}, 32'h0);
    check("rst_err", {31'b0, err_o}, 32'h0);
    check("rst_adr", wbm_adr_o, 32'h0);
    reset_ni = 1'b1;

    // Zero-wait slave, done on first poll
    ws = 0;
    done_at = 1;
    set_model(100, 7, 1'b0);
    base = log_adr.size();
    run_req(100, 7, 0, lat, q, r, e);
    check("t1_latency", lat, 12);
    check("t1_quotient", q, 32'd14);
    check("t1_remainder", r, 32'd2);
    check("t1_err", {31'b0, e}, 32'h0);
    check("t1_txn_count", log_adr.size() - base, 6);
    wd[0] = 100;
    wd[1] = 7;
    wd[2] = 1;
    if (log_adr.size() >= base + 6) begin
      for (int i = 0; i < 6; i++) begin
        check("t1_adr", log_adr[base+i], BASE + 32'(4 * i));
        check("t1_we", {31'b0, log_we[base+i]}, (i < 3) ? 32'h1 : 32'h0);
        if (i < 3) check("t1_wdat", log_dat[base+i], wd[i]);
      end
    end

    // Three wait states, done on fifth poll
    ws = 3;
    done_at = 5;
    set_model(32'hFFFF_FFFF, 32'h10, 1'b0);
    base = n_stat;
    run_req(32'hFFFF_FFFF, 32'h10, 0, lat, q, r, e);
    check("t2_latency", lat, 50);
    check("t2_quotient", q, 32'h0FFF_FFFF);
    check("t2_remainder", r, 32'hF);
    check("t2_err", {31'b0, e}, 32'h0);
    check("t2_polls", n_stat - base, 5);

    // Slave never acks the divisor write
    ws = 0;
    done_at = 1;
    hang_en = 1'b1;
    hang_adr = BASE + 32'h4;
    set_model(55, 5, 1'b1);
    base = n_dvs_stb;
    n = n_stat;
    run_req(55, 5, 0, lat, q, r, e);
    hang_en = 1'b0;
    check("t3_err", {31'b0, e}, 32'h1);
    check("t3_quotient", q, 32'h0);
    check("t3_remainder", r, 32'h0);
    check("t3_stb_cycles", n_dvs_stb - base, ACK_TMO);
    check("t3_no_polls", n_stat - n, 0);

    // Done never set
    done_at = 0;
    set_model(9, 3, 1'b1);
    base = n_stat;
    run_req(9, 3, 0, lat, q, r, e);
    check("t4_err", {31'b0, e}, 32'h1);
    check("t4_polls", n_stat - base, MAX_POLLS);
    check("t4_quotient", q, 32'h0);

    // Response back-pressure
    ws = 1;
    done_at = 2;
    set_model(1000, 3, 1'b0);
    run_req(1000, 3, 10, lat, q, r, e);
    check("t5_quotient", q, 32'd333);
    check("t5_remainder", r, 32'd1);

    // Reset while polling STATUS
    ws = 0;
    done_at = 0;
    no_rsp = 1'b1;
    @(negedge clk);
    dividend  = 40;
    divisor   = 8;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!(wbm_stb_o && wbm_adr_o == BASE + 32'hC) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach_stat", {31'b0, wbm_stb_o}, 32'h1);
    repeat (3) @(negedge clk);
    #2 reset_ni = 1'b0;
    #1;
    check("t6_cyc_async", {31'b0, wbm_cyc_o}, 32'h0);
    check("t6_stb_async", {31'b0, wbm_stb_o}, 32'h0);
    @(negedge clk);
    reset_ni = 1'b1;
    @(negedge clk);
    check("t6_ready", {31'b0, req_ready_o}, 32'h1);
    repeat (20) @(negedge clk);
    check("t6_idle", {31'b0, wbm_cyc_o}, 32'h0);
    no_rsp = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
